axi_lite_master: RTL and testbench

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

---
 rtl/axi_lite_master.sv | 135 +++++++++++++
 tb/tb_axi_lite_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI read or write
// out, one response back, with a per-phase timeout abort.
module axi_lite_master #(
  parameter int unsigned TIMEOUT    = 1024,
  parameter bit          ADDR_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_write,
  output logic [1:0]  rsp_err,
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  output logic [31:0] axi_awaddr,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [1:0]  b_response
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP
  } state_t;

  state_t      state, state_next;
  logic [31:0] addr_q, wdata_q, cnt, addr_out;
  logic        write_q, aw_done, w_done, started;
  logic        accept, ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_fin, w_fin;
  logic        waiting, tmo_hit, tmo_abort;

  assign addr_out    = ADDR_ALIGN ? {addr_q[31:2], 2'b00} : addr_q;
  assign axi_araddr  = addr_out;
  assign axi_awaddr  = addr_out;
  assign axi_wdata   = wdata_q;
  assign rsp_write   = write_q;

  // started keeps cmd_ready low until the first edge after reset release
  assign cmd_ready   = started && (state == IDLE);
  assign axi_arvalid = (state == RD_ADDR);
  assign axi_rready  = (state == RD_DATA);
  assign axi_awvalid = (state == WR_REQ) && !aw_done;
  assign axi_wvalid  = (state == WR_REQ) && !w_done;
  assign b_ready     = (state == WR_RESP);
  assign rsp_valid   = (state == RESP);

  assign accept  = cmd_valid && cmd_ready;
  assign ar_hs   = axi_arvalid && axi_arready;
  assign r_hs    = axi_rready && axi_rvalid;
  assign aw_hs   = axi_awvalid && axi_awready;
  assign w_hs    = axi_wvalid && axi_wready;
  assign b_hs    = b_ready && b_valid;
  assign aw_fin  = aw_done || aw_hs;
  assign w_fin   = w_done || w_hs;
  assign waiting = (state == RD_ADDR) || (state == RD_DATA) ||
                   (state == WR_REQ)  || (state == WR_RESP);
  assign tmo_hit = (TIMEOUT != 0) && (cnt == TIMEOUT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // a completing handshake is checked before the timeout so it always wins
  always_comb begin
    state_next = state;
    tmo_abort  = 1'b0;
    case (state)
      IDLE:    if (accept) state_next = cmd_write ? WR_REQ : RD_ADDR;
      RD_ADDR: if (ar_hs) state_next = RD_DATA;
               else if (tmo_hit) begin state_next = RESP; tmo_abort = 1'b1; end
      RD_DATA: if (r_hs) state_next = RESP;
               else if (tmo_hit) begin state_next = RESP; tmo_abort = 1'b1; end
      WR_REQ:  if (aw_fin && w_fin) state_next = WR_RESP;
               else if (tmo_hit) begin state_next = RESP; tmo_abort = 1'b1; end
      WR_RESP: if (b_hs) state_next = RESP;
               else if (tmo_hit) begin state_next = RESP; tmo_abort = 1'b1; end
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 2'b00;
    end else begin
      started <= 1'b1;
      if (state_next != state) cnt <= '0;
      else if (waiting)        cnt <= cnt + 32'd1;

      if (accept) begin
        addr_q    <= cmd_addr;
        wdata_q   <= cmd_wdata;
        write_q   <= cmd_write;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
        rsp_rdata <= '0;
        rsp_err   <= 2'b00;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;

      if (tmo_abort) rsp_err <= 2'b11;
      else if (r_hs) begin
        rsp_rdata <= axi_rdata;
        rsp_err   <= 2'b00;
      end else if (b_hs) begin
        rsp_err <= (b_response != 2'b00) ? 2'b10 : 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: directed vector table, hand-written reset/stray
// sequences and randomized transactions against a delay-arithmetic model.
module tb_axi_lite_master;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_write;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] axi_araddr, axi_awaddr, axi_wdata;
  logic        axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, b_ready;
  logic        axi_arready = 1'b0, axi_rvalid = 1'b0, axi_awready = 1'b0;
  logic        axi_wready = 1'b0, b_valid = 1'b0;
  logic [31:0] axi_rdata = '0;
  logic [1:0]  b_response = 2'b00;

  int checks = 0;
  int failures = 0;

  axi_lite_master #(.TIMEOUT(TMO), .ADDR_ALIGN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_write(rsp_write), .rsp_err(rsp_err),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .b_valid(b_valid), .b_ready(b_ready), .b_response(b_response)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          write;
    logic [31:0] addr, wdata, rdata;
    int unsigned ar_d, r_d, aw_d, w_d, b_d, hold;
    logic [1:0]  bresp;
    logic [1:0]  exp_err;
    int unsigned exp_lat;
    logic [31:0] exp_rdata;
  } txn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(bit w, logic [31:0] a, logic [31:0] wd, logic [31:0] rd,
                              int unsigned ard, int unsigned rdd, int unsigned awd,
                              int unsigned wdd, int unsigned bd, logic [1:0] br,
                              int unsigned hold, logic [1:0] err, int unsigned lat);
    txn_t t;
    t.write = w; t.addr = a; t.wdata = wd; t.rdata = rd;
    t.ar_d = ard; t.r_d = rdd; t.aw_d = awd; t.w_d = wdd; t.b_d = bd;
    t.bresp = br; t.hold = hold; t.exp_err = err; t.exp_lat = lat;
    t.exp_rdata = w ? 32'h0 : rd;
    return t;
  endfunction

  // Slave delays are cycles a valid/ready is seen before the slave answers;
  // a phase completes only if its delay is below TMO, else it aborts after TMO.
  function automatic txn_t model(txn_t t);
    int unsigned m;
    t.exp_rdata = 32'h0;
    if (!t.write) begin
      if (t.ar_d >= TMO) begin t.exp_err = 2'b11; t.exp_lat = 1 + TMO; end
      else if (t.r_d >= TMO) begin t.exp_err = 2'b11; t.exp_lat = 1 + (t.ar_d + 1) + TMO; end
      else begin t.exp_err = 2'b00; t.exp_lat = 3 + t.ar_d + t.r_d; t.exp_rdata = t.rdata; end
    end else begin
      m = (t.aw_d > t.w_d) ? t.aw_d : t.w_d;
      if (m >= TMO) begin t.exp_err = 2'b11; t.exp_lat = 1 + TMO; end
      else if (t.b_d >= TMO) begin t.exp_err = 2'b11; t.exp_lat = 1 + (m + 1) + TMO; end
      else begin
        t.exp_err = (t.bresp != 2'b00) ? 2'b10 : 2'b00;
        t.exp_lat = 1 + (m + 1) + (t.b_d + 1);
      end
    end
    return t;
  endfunction

  function automatic int unsigned vcyc(int unsigned d);
    return (d + 1 < TMO) ? d + 1 : TMO;
  endfunction

  task automatic run_txn(input txn_t t);
    int unsigned ar_hi, r_hi, aw_hi, w_hi, b_hi, ar_n, r_n, aw_n, w_n, b_n;
    int unsigned lat, waitc, bad, m;
    bit got, rd_reach, b_reach;
    logic [31:0] exp_addr;
    exp_addr = t.addr & 32'hFFFF_FFFC;
    {ar_hi, r_hi, aw_hi, w_hi, b_hi, ar_n, r_n, aw_n, w_n, b_n} = '0;
    bad = 0; lat = 0; got = 1'b0;
    @(negedge clk);
    waitc = 0;
    while (!cmd_ready && waitc < 20) begin @(negedge clk); waitc++; end
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = t.write; cmd_addr = t.addr; cmd_wdata = t.wdata;
    @(posedge clk);
    for (int unsigned k = 1; k <= 200 && !got; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      {axi_arready, axi_rvalid, axi_awready, axi_wready, b_valid} = '0;
      axi_rdata = '0; b_response = 2'b00;
      if (rsp_valid) begin
        got = 1'b1; lat = k;
      end else begin
        if (axi_arvalid) begin
          ar_hi++;
          if (axi_araddr !== exp_addr) bad++;
          axi_arready = (ar_hi > t.ar_d);
          if (axi_arready) ar_n++;
        end
        if (axi_rready) begin
          r_hi++;
          axi_rvalid = (r_hi > t.r_d);
          if (axi_rvalid) begin axi_rdata = t.rdata; r_n++; end
        end
        if (axi_awvalid) begin
          aw_hi++;
          if (axi_awaddr !== exp_addr) bad++;
          axi_awready = (aw_hi > t.aw_d);
          if (axi_awready) aw_n++;
        end
        if (axi_wvalid) begin
          w_hi++;
          if (axi_wdata !== t.wdata) bad++;
          axi_wready = (w_hi > t.w_d);
          if (axi_wready) w_n++;
        end
        if (b_ready) begin
          b_hi++;
          b_valid = (b_hi > t.b_d);
          if (b_valid) begin b_response = t.bresp; b_n++; end
        end
      end
    end
    chk("rsp_seen", {31'b0, got}, 32'd1);
    if (!got) return;
    chk("latency", lat, t.exp_lat);
    chk("rsp_err", {30'b0, rsp_err}, {30'b0, t.exp_err});
    chk("rsp_write", {31'b0, rsp_write}, {31'b0, t.write});
    if (t.exp_err != 2'b11) chk("rsp_rdata", rsp_rdata, t.exp_rdata);
    chk("addr_data_bad", bad, 0);
    m = (t.aw_d > t.w_d) ? t.aw_d : t.w_d;
    rd_reach = !t.write && (t.ar_d < TMO);
    b_reach  = t.write && (m < TMO);
    chk("ar_cycles", ar_hi, t.write ? 0 : vcyc(t.ar_d));
    chk("ar_hs", ar_n, (!t.write && t.ar_d < TMO) ? 1 : 0);
    chk("r_cycles", r_hi, rd_reach ? vcyc(t.r_d) : 0);
    chk("r_hs", r_n, (rd_reach && t.r_d < TMO) ? 1 : 0);
    chk("aw_cycles", aw_hi, t.write ? vcyc(t.aw_d) : 0);
    chk("aw_hs", aw_n, (t.write && t.aw_d < TMO) ? 1 : 0);
    chk("w_cycles", w_hi, t.write ? vcyc(t.w_d) : 0);
    chk("w_hs", w_n, (t.write && t.w_d < TMO) ? 1 : 0);
    chk("b_cycles", b_hi, b_reach ? vcyc(t.b_d) : 0);
    chk("b_hs", b_n, (b_reach && t.b_d < TMO) ? 1 : 0);
    chk("axi_quiet_resp", {27'b0, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, b_ready}, 32'd0);
    for (int unsigned h = 0; h < t.hold; h++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_err", {30'b0, rsp_err}, {30'b0, t.exp_err});
      chk("hold_write", {31'b0, rsp_write}, {31'b0, t.write});
      if (t.exp_err != 2'b11) chk("hold_rdata", rsp_rdata, t.exp_rdata);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", {30'b0, rsp_valid, cmd_ready}, 32'd1);
  endtask

  function automatic int unsigned rdly();
    if ($urandom_range(0, 9) < 8) return $urandom_range(0, 3);
    return $urandom_range(14, 17);
  endfunction

  txn_t tbl[11];
  txn_t rt;

  initial begin
    tbl[0]  = mk(0, 32'h4,  32'h0, 32'h0000_000A, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3);
    tbl[1]  = mk(1, 32'h0,  32'h5, 32'h0, 0, 0, 0, 2, 0, 2'b00, 1, 2'b00, 5);
    tbl[2]  = mk(1, 32'h8,  32'hDEAD_BEEF, 32'h0, 0, 0, 0, 0, 0, 2'b10, 5, 2'b10, 3);
    tbl[3]  = mk(0, 32'hC,  32'h0, 32'h1234, 100, 0, 0, 0, 0, 2'b00, 0, 2'b11, 17);
    tbl[4]  = mk(0, 32'h10, 32'h0, 32'hCAFE_0001, 15, 0, 0, 0, 0, 2'b00, 2, 2'b00, 18);
    tbl[5]  = mk(0, 32'h14, 32'h0, 32'h9, 0, 16, 0, 0, 0, 2'b00, 0, 2'b11, 18);
    tbl[6]  = mk(1, 32'h18, 32'h66, 32'h0, 0, 0, 0, 16, 0, 2'b00, 0, 2'b11, 17);
    tbl[7]  = mk(1, 32'h1C, 32'h67, 32'h0, 0, 0, 0, 0, 16, 2'b00, 1, 2'b11, 18);
    tbl[8]  = mk(1, 32'h13, 32'hA5A5_5A5A, 32'h0, 0, 0, 3, 0, 0, 2'b00, 0, 2'b00, 6);
    tbl[9]  = mk(1, 32'h24, 32'h1, 32'h0, 0, 0, 15, 15, 15, 2'b01, 0, 2'b10, 33);
    tbl[10] = mk(0, 32'h7,  32'h0, 32'h0000_0055, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3);

    // reset state
    #3;
    chk("rst_ctrl", {24'b0, cmd_ready, rsp_valid, rsp_write, axi_arvalid, axi_rready,
                     axi_awvalid, axi_wvalid, b_ready}, 32'd0);
    chk("rst_data", rsp_rdata | axi_araddr | axi_awaddr | axi_wdata | {30'b0, rsp_err}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("cmd_ready_before_edge", {31'b0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    chk("cmd_ready_after_edge", {31'b0, cmd_ready}, 32'd1);

    // stray rvalid / bvalid while idle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      axi_rvalid = 1'b1; b_valid = 1'b1; axi_rdata = 32'hBAD0_BAD0; b_response = 2'b10;
      #1 chk("stray_ignored", {29'b0, axi_rready, b_ready, cmd_ready}, 32'd1);
    end
    @(negedge clk);
    axi_rvalid = 1'b0; b_valid = 1'b0; axi_rdata = '0; b_response = 2'b00;
    chk("stray_still_idle", {30'b0, rsp_valid, cmd_ready}, 32'd1);
    run_txn(tbl[10]);

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    // reset while in WR_REQ
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h77;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_wr_req", {30'b0, axi_awvalid, axi_wvalid}, 32'd3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ctrl", {24'b0, cmd_ready, rsp_valid, rsp_write, axi_arvalid, axi_rready,
                           axi_awvalid, axi_wvalid, b_ready}, 32'd0);
    chk("async_rst_data", rsp_rdata | axi_araddr | axi_awaddr | axi_wdata | {30'b0, rsp_err}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_cmd_ready_low", {31'b0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rel_cmd_ready_high", {30'b0, rsp_valid, cmd_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_rsp_after_abort", {30'b0, rsp_valid, axi_awvalid}, 32'd0);
    end

    // randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      rt.write = $urandom_range(0, 1) == 1;
      rt.addr  = $urandom;
      rt.wdata = $urandom;
      rt.rdata = $urandom;
      rt.ar_d = rdly(); rt.r_d = rdly(); rt.aw_d = rdly(); rt.w_d = rdly(); rt.b_d = rdly();
      rt.bresp = 2'($urandom_range(0, 3));
      rt.hold  = $urandom_range(0, 3);
      rt = model(rt);
      run_txn(rt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
